// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-requester round-robin arbiter with registered one-hot grant
// Grants are held until done, owner req drop, or HOLD_LIMIT forced revoke; one idle bubble between grants.
module rr_arbiter_4 #(
  parameter int HOLD_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [7:0] LIMIT_M1 = 8'(HOLD_LIMIT - 1);

  state_t     r_state, w_state_next;
  logic [3:0] r_grant, w_grant_next;
  logic [1:0] r_owner, w_owner_next;
  logic [1:0] r_ptr, w_ptr_next;
  logic [7:0] r_hold_cnt, w_hold_cnt_next;
  logic       r_grant_valid;
  logic       r_timeout, w_timeout_next;
  logic [1:0] w_win_idx;
  logic [1:0] w_probe;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    w_win_idx = r_ptr;
    w_probe   = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_probe = r_ptr + 2'(k);
      if (req[w_probe]) w_win_idx = w_probe;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_grant_next    = r_grant;
    w_owner_next    = r_owner;
    w_ptr_next      = r_ptr;
    w_hold_cnt_next = r_hold_cnt;
    w_timeout_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req != 4'b0000) begin
          w_grant_next    = 4'(1) << w_win_idx;
          w_owner_next    = w_win_idx;
          w_hold_cnt_next = 8'd0;
          w_state_next    = S_GRANT;
        end
      end
      S_GRANT: begin
        if (done || !req[r_owner]) begin
          w_grant_next = 4'b0000;
          w_ptr_next   = r_owner + 2'd1;
          w_state_next = S_IDLE;
        end else if ((HOLD_LIMIT != 0) && (r_hold_cnt == LIMIT_M1)) begin
          w_grant_next   = 4'b0000;
          w_ptr_next     = r_owner + 2'd1;
          w_timeout_next = 1'b1;
          w_state_next   = S_IDLE;
        end else if (r_hold_cnt != 8'hFF) begin
          w_hold_cnt_next = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_grant_next = 4'b0000;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_grant       <= 4'b0000;
      r_owner       <= 2'd0;
      r_ptr         <= 2'd0;
      r_hold_cnt    <= 8'd0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_grant       <= w_grant_next;
      r_owner       <= w_owner_next;
      r_ptr         <= w_ptr_next;
      r_hold_cnt    <= w_hold_cnt_next;
      r_grant_valid <= |w_grant_next;
      r_timeout     <= w_timeout_next;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign timeout     = r_timeout;

endmodule
